// File: rtl/id_stage_if.sv
// Fetch-to-decode handshake bundle: instruction word, pc, valid/ready and flush.
interface id_stage_if #(
  parameter int PC_W = 16
);
  logic [31:0]     inst_i;
  logic [PC_W-1:0] pc_i;
  logic            inst_valid_i;
  logic            inst_ready_o;
  logic            flush_i;

  modport master (
    output inst_i, pc_i, inst_valid_i, flush_i,
    input  inst_ready_o
  );

  modport slave (
    input  inst_i, pc_i, inst_valid_i, flush_i,
    output inst_ready_o
  );
endinterface

// File: rtl/id_stage.sv
// Decode stage: decodes LUI/AUIPC/OP-IMM/OP into the ID/EX register and resolves RAW hazards on EX.
// Define ID_BYPASS_EN to forward the EX result instead of interlocking for one cycle.
module id_stage #(
  parameter int PC_W = 16,
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  id_stage_if.slave       fetch,
  output logic [4:0]      rs1_addr_o,
  output logic [4:0]      rs2_addr_o,
  input  logic [XLEN-1:0] rs1_data_i,
  input  logic [XLEN-1:0] rs2_data_i,
  input  logic            ex_rd_we_i,
  input  logic [4:0]      ex_rd_addr_i,
  input  logic [XLEN-1:0] ex_rd_data_i,
  output logic [PC_W-1:0] pc_o,
  output logic [6:0]      opcode_o,
  output logic [6:0]      funct7_o,
  output logic [2:0]      funct3_o,
  output logic [XLEN-1:0] imm_o,
  output logic [XLEN-1:0] rs1_data_o,
  output logic [XLEN-1:0] rs2_data_o,
  output logic            rd_we_o,
  output logic [4:0]      rd_addr_o,
  output logic            valid_o,
  output logic            illegal_o
);

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  logic [31:0] inst;
  logic [6:0]  opcode;
  logic [4:0]  rd;
  logic        is_lui, is_auipc, is_op_imm, is_op, is_u, legal;
  logic [XLEN-1:0] imm;

  assign inst      = fetch.inst_i;
  assign opcode    = inst[6:0];
  assign rd        = inst[11:7];
  assign is_lui    = (opcode == OPC_LUI);
  assign is_auipc  = (opcode == OPC_AUIPC);
  assign is_op_imm = (opcode == OPC_OP_IMM);
  assign is_op     = (opcode == OPC_OP);
  assign is_u      = is_lui || is_auipc;
  assign legal     = is_u || is_op_imm || is_op;

  assign imm = is_u      ? XLEN'($signed({inst[31:12], 12'b0})) :
               is_op_imm ? XLEN'($signed(inst[31:20]))          : '0;

  assign rs1_addr_o = inst[19:15];
  assign rs2_addr_o = inst[24:20];

  // Per-source hazard detection and operand selection; index 0 is rs1, index 1 is rs2.
  logic [4:0]      src_addr   [2];
  logic            src_use    [2];
  logic [XLEN-1:0] src_rf     [2];
  logic            src_hazard [2];
  logic [XLEN-1:0] src_data   [2];

  assign src_addr[0] = inst[19:15];
  assign src_addr[1] = inst[24:20];
  assign src_use[0]  = is_op_imm || is_op;
  assign src_use[1]  = is_op;
  assign src_rf[0]   = rs1_data_i;
  assign src_rf[1]   = rs2_data_i;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_src
      assign src_hazard[gi] = src_use[gi] && (src_addr[gi] != 5'd0) &&
                              ex_rd_we_i && (ex_rd_addr_i == src_addr[gi]);
`ifdef ID_BYPASS_EN
      assign src_data[gi] = (!src_use[gi] || src_addr[gi] == 5'd0) ? '0 :
                            src_hazard[gi] ? ex_rd_data_i : src_rf[gi];
`else
      assign src_data[gi] = (!src_use[gi] || src_addr[gi] == 5'd0) ? '0 : src_rf[gi];
`endif
    end
  endgenerate

  logic ready;
  logic accept;

`ifdef ID_BYPASS_EN
  assign ready = 1'b1;
`else
  // Interlock: a hazard holds the instruction one cycle until EX retires into the regfile.
  logic hazard;
  logic unused_ex_data;
  assign hazard         = src_hazard[0] || src_hazard[1];
  assign ready          = fetch.flush_i || !hazard;
  assign unused_ex_data = ^ex_rd_data_i;
`endif

  assign fetch.inst_ready_o = ready;
  assign accept             = fetch.inst_valid_i && ready && !fetch.flush_i;

  logic [PC_W-1:0] pc_reg, pc_next;
  logic [6:0]      opcode_reg, opcode_next;
  logic [6:0]      funct7_reg, funct7_next;
  logic [2:0]      funct3_reg, funct3_next;
  logic [XLEN-1:0] imm_reg, imm_next;
  logic [XLEN-1:0] rs1_data_reg, rs1_data_next;
  logic [XLEN-1:0] rs2_data_reg, rs2_data_next;
  logic            rd_we_reg, rd_we_next;
  logic [4:0]      rd_addr_reg, rd_addr_next;
  logic            valid_reg, valid_next;
  logic            illegal_reg, illegal_next;

  // Default is a bubble; an illegal instruction keeps only its pc and the illegal pulse.
  always_comb begin
    pc_next       = '0;
    opcode_next   = '0;
    funct7_next   = '0;
    funct3_next   = '0;
    imm_next      = '0;
    rs1_data_next = '0;
    rs2_data_next = '0;
    rd_we_next    = 1'b0;
    rd_addr_next  = '0;
    valid_next    = 1'b0;
    illegal_next  = 1'b0;
    if (accept) begin
      pc_next = fetch.pc_i;
      if (legal) begin
        opcode_next   = opcode;
        funct7_next   = inst[31:25];
        funct3_next   = inst[14:12];
        imm_next      = imm;
        rs1_data_next = src_data[0];
        rs2_data_next = src_data[1];
        rd_we_next    = (rd != 5'd0);
        rd_addr_next  = rd;
        valid_next    = 1'b1;
      end else begin
        illegal_next  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_reg       <= '0;
      opcode_reg   <= '0;
      funct7_reg   <= '0;
      funct3_reg   <= '0;
      imm_reg      <= '0;
      rs1_data_reg <= '0;
      rs2_data_reg <= '0;
      rd_we_reg    <= 1'b0;
      rd_addr_reg  <= '0;
      valid_reg    <= 1'b0;
      illegal_reg  <= 1'b0;
    end else begin
      pc_reg       <= pc_next;
      opcode_reg   <= opcode_next;
      funct7_reg   <= funct7_next;
      funct3_reg   <= funct3_next;
      imm_reg      <= imm_next;
      rs1_data_reg <= rs1_data_next;
      rs2_data_reg <= rs2_data_next;
      rd_we_reg    <= rd_we_next;
      rd_addr_reg  <= rd_addr_next;
      valid_reg    <= valid_next;
      illegal_reg  <= illegal_next;
    end
  end

  assign pc_o       = pc_reg;
  assign opcode_o   = opcode_reg;
  assign funct7_o   = funct7_reg;
  assign funct3_o   = funct3_reg;
  assign imm_o      = imm_reg;
  assign rs1_data_o = rs1_data_reg;
  assign rs2_data_o = rs2_data_reg;
  assign rd_we_o    = rd_we_reg;
  assign rd_addr_o  = rd_addr_reg;
  assign valid_o    = valid_reg;
  assign illegal_o  = illegal_reg;

endmodule
